// File: rtl/stepping_rebarrel.sv
// stepping_rebarrel: registered lane rotator with a stepping offset.
// Each accepted word is left-rotated by the held offset. The offset then
// advances according to the stepping mode, and out_notch marks a word whose
// step wrapped the offset. Both sides use valid/ready, with one output register.
module stepping_rebarrel #(
    parameter  int LANES  = 8,
    parameter  int LANE_W = 1,
    parameter  int STEP   = 2,
    localparam int OW     = $clog2(LANES),
    localparam int DW     = LANES * LANE_W
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [1:0]    mode,
    input  logic          cfg_load,
    input  logic [OW-1:0] cfg_offset,
    input  logic          carry_in,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic          out_notch,
    output logic [OW-1:0] offset
);

    localparam logic [1:0]    MODE_HOLD  = 2'b00;
    localparam logic [1:0]    MODE_FWD   = 2'b01;
    localparam logic [1:0]    MODE_CARRY = 2'b10;
    localparam logic [1:0]    MODE_BWD   = 2'b11;

    // Offsets are kept as multiples of STEP, so the low bits are always cleared on load.
    localparam logic [OW-1:0] CFG_MASK  = ~OW'(STEP - 1);
    localparam logic [OW-1:0] STEP_OW   = OW'(STEP);
    localparam logic [OW-1:0] FWD_WRAP  = OW'(LANES - STEP);

    logic          acc;
    logic          step_fwd;
    logic          step_bwd;
    logic          wrap;
    logic [DW-1:0] rot;

    assign in_ready = !out_valid || out_ready;
    assign acc      = in_valid && in_ready;

    // Work out the step direction for the current word from mode and carry_in.
    always_comb begin
        step_fwd = 1'b0;
        step_bwd = 1'b0;
        case (mode)
            MODE_HOLD:  ;
            MODE_FWD:   step_fwd = 1'b1;
            MODE_CARRY: step_fwd = carry_in;
            MODE_BWD:   step_bwd = 1'b1;
            default:    ;
        endcase
        wrap = (step_fwd && (offset == FWD_WRAP)) ||
               (step_bwd && (offset == '0));
    end

    // Lane 0 is the MSB lane. Output lane i takes input lane (i + offset) mod LANES.
    // The OW-bit sum wraps mod LANES.
    always_comb begin
        rot = '0;
        for (int i = 0; i < LANES; i++) begin
            logic [OW-1:0] src;
            src = OW'(i) + offset;
            rot[(LANES-1-i)*LANE_W +: LANE_W] = in_data[(LANES-1-int'(src))*LANE_W +: LANE_W];
        end
    end

    // Output register stage: it loads on accept and drains on out_ready.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_notch <= 1'b0;
        end else if (acc) begin
            out_valid <= 1'b1;
            out_data  <= rot;
            // A same-cycle reload replaces the step, so that word cannot report a wrap.
            out_notch <= wrap && !cfg_load;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Offset register: a config load wins over a step, and steps occur only on accepted words.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            offset <= '0;
        end else if (cfg_load) begin
            offset <= cfg_offset & CFG_MASK;
        end else if (acc && step_fwd) begin
            offset <= offset + STEP_OW;
        end else if (acc && step_bwd) begin
            offset <= offset - STEP_OW;
        end
    end

endmodule

// File: doc/stepping_rebarrel.md
# stepping_rebarrel

Parametrised, registered lane rotator for the cipher datapath. It is the stateful successor of the fixed 4-way rebarrel. It rotates each accepted word by a held offset, then advances that offset per word under a selectable stepping mode. It emits a notch (wrap) flag so stages can be chained odometer-style, as rotor stages are. Input and output use valid/ready handshakes, with one registered output stage.

## Interface
- `LANES`, default 8: lanes per word; power of two, ≥2.
- `LANE_W`, default 1: bits per lane; data width `DW = LANES*LANE_W`.
- `STEP`, default 2: offset increment in lanes; power of two, < `LANES`.
- `OW = $clog2(LANES)`: derived, not overridable.

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `mode` in 2: 00 hold, 01 step forward every word, 10 step forward on `carry_in`, 11 step backward every word.
- `cfg_load` in 1: load `cfg_offset` into the offset register.
- `cfg_offset` in OW: new offset; low `$clog2(STEP)` bits are forced to 0 on load.
- `carry_in` in 1: notch from the previous stage; sampled with the accepted word, used only in mode 10.
- `in_valid` in 1, `in_data` in DW, `in_ready` out 1: input handshake.
- `out_valid` out 1, `out_data` out DW, `out_ready` in 1: output handshake.
- `out_notch` out 1: sideband qualified by `out_valid`; the word caused an offset wrap.
- `offset` out OW: current offset register (debug/chaining).

## Operation
- Lane indexing: lane 0 is the most significant lane. Rotation: `out lane i = in lane (i + offset) mod LANES`, which is a left rotate by `offset` lanes.
- Accept: `acc = in_valid && in_ready`, where `in_ready = !out_valid || out_ready`.
- On `acc`:
  - `out_data` takes the rotation using the offset value before any update this cycle.
  - `out_valid` is set to 1.
  - The offset updates per `mode`:
    - 00: unchanged.
    - 01: `offset + STEP`.
    - 10: `offset + STEP` if `carry_in`, else unchanged.
    - 11: `offset - STEP`.
  - Arithmetic is OW-bit and wraps naturally mod `LANES`.
- Wrap detection:
  - Forward: old offset = `LANES-STEP` and a forward step occurs.
  - Backward: old offset = 0 and a backward step occurs.
  - `out_notch` is registered with the word; it is 0 when no wrap occurs.
- `out_valid` clears on `out_ready && !acc`.
- `cfg_load` (any cycle) writes the masked `cfg_offset`. It beats any same-cycle step. A word accepted in that cycle still rotates by the old offset, and that word's `out_notch` is 0.
- Mode 00 never raises `out_notch`. `mode` may change between words with no flush.

## Timing
- Reset (async assert, sync release): `offset`=0, `out_valid`=0, `out_data`=0, `out_notch`=0. `in_ready`=1 combinationally after reset.
- Latency: word accepted at edge N appears at `out_valid`/`out_data` after edge N, i.e. one cycle.
- Throughput: one word per cycle while `out_ready`=1; `in_ready` depends combinationally on `out_ready`.
- Backpressure (`out_valid && !out_ready`):
  - `in_ready`=0.
  - `out_data`/`out_notch` are held stable.
  - The offset does not step; `cfg_load` is still honoured.
- Full-rotation period in modes 01/11: `LANES/STEP` words per notch.
- Reset asserted mid-stream: the pending output word is dropped, the offset returns to 0, and no notch is emitted.
- In mode 10, when `carry_in` is asserted without `acc` it is ignored, and no step occurs.

## Test plan
- Reset, `cfg_load`=1 with `cfg_offset`=2, mode 00, send 8'h80 → `out_data`=8'h02 one cycle later, `out_notch`=0, `offset` stays 2.
- Mode 01 from offset 0, four back-to-back 8'h80 words, `out_ready`=1 → outputs 8'h80, 8'h02, 8'h08, 8'h20; `out_notch` = 0,0,0,1; `offset` ends at 0.
- Mode 11 from offset 0, three 8'h80 words → outputs 8'h80, 8'h20, 8'h08; `out_notch` = 1,0,0; `offset` ends at 2.
- Mode 10 with `carry_in` pattern 0,1,0,1 on four 8'h80 words from offset 6 → outputs 8'h20, 8'h20, 8'h80, 8'h80; `out_notch` = 0,1,0,0.
- Backpressure: hold `out_ready`=0 for 3 cycles with `in_valid`=1 in mode 01 → `in_ready`=0, `out_data` stable, `offset` unchanged. Release → one word per cycle resumes with no loss or duplication.
- `cfg_load` with `cfg_offset`=5 in the same cycle as an accepted word at offset 6 in mode 01 → that word rotates by 6 with `out_notch`=0, `offset` becomes 4. Async `reset_n` pulse mid-stream → `out_valid` drops immediately and `offset`=0.
